result_fifo: RTL and testbench

RESULT_FIFO -- requirements
Module: result_fifo

---
 rtl/hpu_stream_pkg.sv | 12 +
 rtl/result_fifo_mem.sv | 27 ++
 rtl/result_fifo.sv | 148 ++++++++++++++
 tb/tb_result_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hpu_stream_pkg.sv
// Shared widths and depth defaults for the HPU result stream path.
package hpu_stream_pkg;

  localparam int HPU_DATA_W     = 64;
  localparam int HPU_STRB_W     = HPU_DATA_W / 8;
  localparam int HPU_DEPTH_LOG2 = 4;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/result_fifo_mem.sv
// Simple dual-port beat storage: one synchronous write port, one asynchronous read port.
// No reset on the array; the pointers in the owner decide which entries are meaningful.
module result_fifo_mem
  import hpu_stream_pkg::*;
#(
  parameter int AW = HPU_DEPTH_LOG2,
  parameter int W  = HPU_DATA_W + HPU_STRB_W + 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [0:(1 << AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_fifo.sv
// FWFT result FIFO, HPU output stage -> DMA S2MM; push-to-pop latency 1, S_AXIS_TREADY drops only when full.
// RESULT_FIFO_STORE_FWD_EN: hold beats until a whole packet is stored, forced cut-through if full with none.
module result_fifo
  import hpu_stream_pkg::*;
#(
  parameter int DEPTH_LOG2 = HPU_DEPTH_LOG2,
  parameter int DATA_W     = HPU_DATA_W
) (
  input  logic                AXIS_ACLK,
  input  logic                AXIS_ARESETN,
  input  logic                clr,
  input  logic                S_AXIS_TVALID,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0] S_AXIS_TSTRB,
  input  logic                S_AXIS_TLAST,
  output logic                S_AXIS_TREADY,
  output logic                M_AXIS_TVALID,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic [DATA_W/8-1:0] M_AXIS_TSTRB,
  output logic                M_AXIS_TLAST,
  input  logic                M_AXIS_TREADY,
  output logic [DEPTH_LOG2:0] level,
  output logic [15:0]         pkt_cnt,
  output logic                ovf_err
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [STRB_W-1:0] tstrb;
    logic              tlast;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;
  logic                  full, empty, push, pop, pop_last, mem_we;
  beat_t                 wr_beat, rd_beat;

  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign push     = S_AXIS_TVALID & ~full;
  assign pop      = M_AXIS_TVALID & M_AXIS_TREADY;
  assign pop_last = pop & rd_beat.tlast;
  assign mem_we   = push & ~clr;

  assign wr_beat.tdata = S_AXIS_TDATA;
  assign wr_beat.tstrb = S_AXIS_TSTRB;
  assign wr_beat.tlast = S_AXIS_TLAST;

  result_fifo_mem #(
    .AW (DEPTH_LOG2),
    .W  (BEAT_W)
  ) u_mem (
    .clk_i   (AXIS_ACLK),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_beat),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_beat)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkt_cnt_d = pkt_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (pop_last) pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

  // clr shares the reset path so a run stop leaves the same state as a hard reset.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN || clr) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

`ifdef RESULT_FIFO_STORE_FWD_EN
  logic [DEPTH_LOG2:0] cmpl_q, cmpl_d;
  logic                force_q, force_d;
  logic                ovf_q, ovf_d;
  logic                starved;

  // Full with no complete packet would deadlock the producer, so let beats through early.
  assign starved       = full & (cmpl_q == '0);
  assign M_AXIS_TVALID = ~empty & ((cmpl_q != '0) | force_q | starved);

  always_comb begin
    cmpl_d  = cmpl_q;
    force_d = force_q;
    unique case ({push & S_AXIS_TLAST, pop_last})
      2'b10:   cmpl_d = cmpl_q + LVL_ONE;
      2'b01:   cmpl_d = cmpl_q - LVL_ONE;
      default: cmpl_d = cmpl_q;
    endcase
    if (starved)  force_d = 1'b1;
    if (pop_last) force_d = 1'b0;
    ovf_d = ovf_q | starved;
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN || clr) begin
      cmpl_q  <= '0;
      force_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cmpl_q  <= cmpl_d;
      force_q <= force_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign M_AXIS_TVALID = ~empty;
  assign ovf_err       = 1'b0;
`endif

  assign S_AXIS_TREADY = ~full;
  assign M_AXIS_TDATA  = rd_beat.tdata;
  assign M_AXIS_TSTRB  = rd_beat.tstrb;
  assign M_AXIS_TLAST  = rd_beat.tlast;
  assign level         = level_q;
  assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_result_fifo.sv
// Directed bench for result_fifo; expectations follow RESULT_FIFO_STORE_FWD_EN when defined.
module tb_result_fifo;
  import hpu_stream_pkg::*;

  localparam int DW = HPU_DATA_W;
  localparam int SW = HPU_STRB_W;
  localparam int AW = HPU_DEPTH_LOG2;
`ifdef RESULT_FIFO_STORE_FWD_EN
  localparam logic SF_EN = 1'b1;
`else
  localparam logic SF_EN = 1'b0;
`endif

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          clr  = 1'b0;
  logic          s_vld = 1'b0;
  logic [DW-1:0] s_dat = '0;
  logic [SW-1:0] s_strb = '0;
  logic          s_last = 1'b0;
  logic          s_rdy;
  logic          m_vld;
  logic [DW-1:0] m_dat;
  logic [SW-1:0] m_strb;
  logic          m_last;
  logic          m_rdy = 1'b0;
  logic [AW:0]   level;
  logic [15:0]   pkt_cnt;
  logic          ovf_err;

  always #5 clk = ~clk;

  result_fifo dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rstn),
    .clr           (clr),
    .S_AXIS_TVALID (s_vld),
    .S_AXIS_TDATA  (s_dat),
    .S_AXIS_TSTRB  (s_strb),
    .S_AXIS_TLAST  (s_last),
    .S_AXIS_TREADY (s_rdy),
    .M_AXIS_TVALID (m_vld),
    .M_AXIS_TDATA  (m_dat),
    .M_AXIS_TSTRB  (m_strb),
    .M_AXIS_TLAST  (m_last),
    .M_AXIS_TREADY (m_rdy),
    .level         (level),
    .pkt_cnt       (pkt_cnt),
    .ovf_err       (ovf_err)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } tb_beat_t;

  tb_beat_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [63:0] d, input logic l, input logic r);
    s_vld  = v;
    s_dat  = d;
    s_strb = ~d[7:0];
    s_last = l;
    m_rdy  = r;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes are decided by values stable at the falling edge.
  always @(negedge clk) begin : mon
    tb_beat_t e;
    if (!rstn || clr) begin
      exp_q.delete();
    end else begin
      if (m_vld && m_rdy) begin
        chk("pop_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pop_dat", m_dat, e.d);
          chk("pop_strb_last", {55'd0, m_last, m_strb}, {55'd0, e.l, e.s});
        end
        n_pop++;
      end
      if (s_vld && s_rdy) exp_q.push_back('{s_dat, s_strb, s_last});
    end
  end

  initial begin
    // Reset state
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_pkt", 64'(pkt_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    chk("rst_mvld", 64'(m_vld), 64'd0);
    chk("rst_srdy", 64'(s_rdy), 64'd1);
    rstn = 1'b1;
    cyc(0, 0, 0, 1);
    chk("rel_srdy", 64'(s_rdy), 64'd1);

    // 8-beat packet, sink always ready
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 64'(i), (i == 8), 1);
      if (i == 1) begin
        chk("t1_lat_vld", 64'(m_vld), 64'(!SF_EN));
        chk("t1_head", m_dat, 64'd1);
      end
    end
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
    chk("t1_level", 64'(level), 64'd0);
    chk("t1_pkt", 64'(pkt_cnt), 64'd1);
    chk("t1_npop", 64'(n_pop), 64'd8);

    // Fill to full with sink stalled, 17th beat held by source
    for (int i = 0; i < 16; i++) cyc(1, 64'h100 + 64'(i), 0, 0);
    chk("t2_srdy_full", 64'(s_rdy), 64'd0);
    chk("t2_level_full", 64'(level), 64'd16);
    chk("t2_vld_full", 64'(m_vld), 64'd1);
    cyc(1, 64'h110, 1, 0);
    cyc(1, 64'h110, 1, 0);
    chk("t2_level_hold", 64'(level), 64'd16);
    chk("t2_srdy_hold", 64'(s_rdy), 64'd0);
    chk("t2_ovf", 64'(ovf_err), 64'(SF_EN));
    cyc(1, 64'h110, 1, 1);
    chk("t2_level_pop", 64'(level), 64'd15);
    chk("t2_srdy_pop", 64'(s_rdy), 64'd1);
    chk("t2_head_pop", m_dat, 64'h101);
    cyc(1, 64'h110, 1, 1);
    chk("t2_level_pp", 64'(level), 64'd15);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1);
    chk("t2_level_end", 64'(level), 64'd0);
    chk("t2_pkt", 64'(pkt_cnt), 64'd2);
    chk("t2_npop", 64'(n_pop), 64'd25);

    clr = 1'b1;
    cyc(0, 0, 0, 0);
    clr = 1'b0;
    chk("clr_pkt", 64'(pkt_cnt), 64'd0);
    chk("clr_ovf", 64'(ovf_err), 64'd0);

    // Steady push+pop at level 5 across several pointer wraps
    for (int i = 0; i < 5; i++) cyc(1, 64'h200 + 64'(i), 1, 0);
    chk("t3_level_pre", 64'(level), 64'd5);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 64'h300 + 64'(i), 1, 1);
      chk("t3_level", 64'(level), 64'd5);
    end
    chk("t3_pkt", 64'(pkt_cnt), 64'd40);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    chk("t3_level_end", 64'(level), 64'd0);
    chk("t3_pkt_end", 64'(pkt_cnt), 64'd45);
    chk("t3_npop", 64'(n_pop), 64'd70);

    // clr at level 9 with pkt_cnt 3; beat in the clr cycle is dropped
    clr = 1'b1;
    cyc(0, 0, 0, 0);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 64'h400 + 64'(i), 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 64'h410 + 64'(i), 1, 0);
    chk("t4_level_pre", 64'(level), 64'd9);
    chk("t4_pkt_pre", 64'(pkt_cnt), 64'd3);
    clr = 1'b1;
    cyc(1, 64'h4ff, 1, 1);
    clr = 1'b0;
    chk("t4_level", 64'(level), 64'd0);
    chk("t4_pkt", 64'(pkt_cnt), 64'd0);
    chk("t4_mvld", 64'(m_vld), 64'd0);
    chk("t4_srdy", 64'(s_rdy), 64'd1);
    cyc(0, 0, 0, 1);
    chk("t4_level_after", 64'(level), 64'd0);
    chk("t4_npop", 64'(n_pop), 64'd73);

    // Packet gating and forced release
    for (int i = 0; i < 3; i++) cyc(1, 64'h500 + 64'(i), 0, 0);
    chk("t5_vld_nolast", 64'(m_vld), 64'(!SF_EN));
    chk("t5_level3", 64'(level), 64'd3);
    cyc(1, 64'h503, 1, 0);
    chk("t5_vld_last", 64'(m_vld), 64'd1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
    chk("t5_pkt1", 64'(pkt_cnt), 64'd1);
    for (int i = 0; i < 16; i++) cyc(1, 64'h600 + 64'(i), 0, 0);
    chk("t5_level16", 64'(level), 64'd16);
    chk("t5_vld_forced", 64'(m_vld), 64'd1);
    chk("t5_ovf_pre", 64'(ovf_err), 64'd0);
    cyc(0, 0, 0, 0);
    chk("t5_ovf", 64'(ovf_err), 64'(SF_EN));
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1);
    chk("t5_level_drain", 64'(level), 64'd0);
    chk("t5_mvld_drain", 64'(m_vld), 64'd0);
    cyc(1, 64'h6ff, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    chk("t5_pkt2", 64'(pkt_cnt), 64'd2);
    chk("t5_ovf_sticky", 64'(ovf_err), 64'(SF_EN));
    chk("t5_npop", 64'(n_pop), 64'd94);

    // Reset mid-packet at level 4
    for (int i = 0; i < 4; i++) cyc(1, 64'h700 + 64'(i), 0, 0);
    chk("t6_level_pre", 64'(level), 64'd4);
    rstn = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_pkt", 64'(pkt_cnt), 64'd0);
    chk("t6_ovf", 64'(ovf_err), 64'd0);
    chk("t6_mvld", 64'(m_vld), 64'd0);
    chk("t6_srdy", 64'(s_rdy), 64'd1);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("t6_mvld_rel", 64'(m_vld), 64'd0);
    chk("t6_npop_stale", 64'(n_pop), 64'd94);
    cyc(1, 64'h7ff, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    chk("t6_pkt_new", 64'(pkt_cnt), 64'd1);
    chk("t6_npop_new", 64'(n_pop), 64'd95);
    chk("t6_level_end", 64'(level), 64'd0);
    chk("end_qempty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
